// File: rtl/rec_play_pkg.sv
// rec_play_pkg: shared types and constants for the record/playback controller.
//   rec_play_state_e : controller state encoding (also driven on o_state)
//   SEC_W            : width of the elapsed-seconds display count
package rec_play_pkg;

    typedef enum logic [2:0] {
        INIT       = 3'd0,
        IDLE       = 3'd1,
        RECD       = 3'd2,
        RECD_PAUSE = 3'd3,
        PLAY       = 3'd4,
        PLAY_PAUSE = 3'd5
    } rec_play_state_e;

    localparam int SEC_W = 6;

endpackage

// File: rtl/rec_play_ctrl_sec_counter.sv
// sec_counter: divides the audio frame tick stream down to whole seconds.
//   clk    in  : clock
//   rst_n  in  : synchronous active-low reset
//   clr    in  : restart the count from zero (priority over counting)
//   en     in  : count ticks only while high
//   tick   in  : one pulse per audio frame
//   sec    out : elapsed seconds, saturating at all-ones
module sec_counter
    import rec_play_pkg::*;
#(
    parameter int SAMPLE_RATE = 32000
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             tick,
    output logic [SEC_W-1:0] sec
);

    localparam int DIV_W = (SAMPLE_RATE > 1) ? $clog2(SAMPLE_RATE) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SAMPLE_RATE - 1);
    localparam logic [SEC_W-1:0] SEC_MAX  = '1;

    // Down-counter; a tick that finds it at zero completes one second.
    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            div_cnt <= DIV_LOAD;
            sec     <= '0;
        end else if (en && tick) begin
            if (div_cnt == '0) begin
                div_cnt <= DIV_LOAD;
                if (sec != SEC_MAX) begin
                    sec <= sec + SEC_W'(1);
                end
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/rec_play_ctrl.sv
// rec_play_ctrl: multi-track record/playback sequencer.
// Sequences codec init, records into / plays from one of 2**TRK_W equal SRAM
// partitions, keeps a per-track recorded length and auto-stops on full/end.
//
// Ports:
//   i_clk, i_rst_n            : clock, synchronous active-low reset
//   i_key_rec/play/stop       : one-cycle key pulses (stop > rec > play)
//   i_track                   : track select, sampled on start from IDLE
//   i_init_done               : codec initialiser finished (level)
//   i_rec_valid               : recorder word ready on the SRAM bus
//   i_play_off                : player read offset within the track
//   i_sample_tick             : one pulse per audio frame
//   o_init_start              : pulse to start the codec initialiser
//   o_rec_start/pause/stop    : pulses to the recorder
//   o_play_start/pause/stop   : pulses to the player
//   o_play_en                 : player enable
//   o_sram_addr, o_sram_we_n  : SRAM address and active-low write enable
//   o_state                   : current state
//   o_sec                     : elapsed seconds of current record/play
//
// Build option REC_PLAY_LOOP_EN: at end of track the player restarts instead
// of stopping (o_play_start pulse, stay in PLAY, seconds cleared).
//
// state      | meaning
// INIT       | codec initialisation, keys ignored
// IDLE       | waiting for rec/play key
// RECD       | writing recorder words into the selected partition
// RECD_PAUSE | recording suspended, position kept
// PLAY       | player enabled, reading the selected partition
// PLAY_PAUSE | player disabled, position kept
module rec_play_ctrl
    import rec_play_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int TRK_W       = 2,
    parameter int SAMPLE_RATE = 32000
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_key_rec,
    input  logic                    i_key_play,
    input  logic                    i_key_stop,
    input  logic [TRK_W-1:0]        i_track,
    input  logic                    i_init_done,
    input  logic                    i_rec_valid,
    input  logic [ADDR_W-TRK_W-1:0] i_play_off,
    input  logic                    i_sample_tick,
    output logic                    o_init_start,
    output logic                    o_rec_start,
    output logic                    o_rec_pause,
    output logic                    o_rec_stop,
    output logic                    o_play_start,
    output logic                    o_play_pause,
    output logic                    o_play_stop,
    output logic                    o_play_en,
    output logic [ADDR_W-1:0]       o_sram_addr,
    output logic                    o_sram_we_n,
    output logic [2:0]              o_state,
    output logic [SEC_W-1:0]        o_sec
);

    localparam int NUM_TRACKS = 2 ** TRK_W;
    localparam int OFF_W      = ADDR_W - TRK_W;
    localparam int LEN_W      = OFF_W + 1;
    localparam logic [OFF_W-1:0] WR_LAST  = '1;
    localparam logic [LEN_W-1:0] FULL_LEN = {1'b1, {OFF_W{1'b0}}};

    rec_play_state_e  state, state_nx;
    logic [TRK_W-1:0] trk, trk_nx;
    logic [OFF_W-1:0] wr_cnt, wr_cnt_nx;
    logic [LEN_W-1:0] len_q [NUM_TRACKS];
    logic             init_fired;

    logic             len_we;
    logic [TRK_W-1:0] len_widx;
    logic [LEN_W-1:0] len_wval;
    logic             sec_clr;
    logic             play_end;

    logic init_start_nx, rec_start_nx, rec_pause_nx, rec_stop_nx;
    logic play_start_nx, play_pause_nx, play_stop_nx;

    // Length is one bit wider than the offset so a full region compares correctly.
    assign play_end = ({1'b0, i_play_off} >= len_q[trk]);

    always_comb begin
        state_nx      = state;
        trk_nx        = trk;
        wr_cnt_nx     = wr_cnt;
        len_we        = 1'b0;
        len_widx      = trk;
        len_wval      = '0;
        sec_clr       = 1'b0;
        init_start_nx = 1'b0;
        rec_start_nx  = 1'b0;
        rec_pause_nx  = 1'b0;
        rec_stop_nx   = 1'b0;
        play_start_nx = 1'b0;
        play_pause_nx = 1'b0;
        play_stop_nx  = 1'b0;

        case (state)
            INIT: begin
                init_start_nx = !init_fired;
                if (i_init_done) begin
                    state_nx = IDLE;
                end
            end
            IDLE: begin
                // A stop key in IDLE swallows any rec/play key of the same cycle.
                if (!i_key_stop) begin
                    if (i_key_rec) begin
                        trk_nx       = i_track;
                        wr_cnt_nx    = '0;
                        len_we       = 1'b1;
                        len_widx     = i_track;
                        len_wval     = '0;
                        rec_start_nx = 1'b1;
                        sec_clr      = 1'b1;
                        state_nx     = RECD;
                    end else if (i_key_play && (len_q[i_track] != '0)) begin
                        trk_nx        = i_track;
                        play_start_nx = 1'b1;
                        sec_clr       = 1'b1;
                        state_nx      = PLAY;
                    end
                end
            end
            RECD: begin
                if (i_rec_valid) begin
                    wr_cnt_nx = wr_cnt + OFF_W'(1);
                end
                if (i_rec_valid && (wr_cnt == WR_LAST)) begin
                    len_we      = 1'b1;
                    len_wval    = FULL_LEN;
                    rec_stop_nx = 1'b1;
                    state_nx    = IDLE;
                end else if (i_key_stop) begin
                    len_we      = 1'b1;
                    len_wval    = {1'b0, wr_cnt};
                    rec_stop_nx = 1'b1;
                    state_nx    = IDLE;
                end else if (i_key_rec) begin
                    rec_pause_nx = 1'b1;
                    state_nx     = RECD_PAUSE;
                end
            end
            RECD_PAUSE: begin
                if (i_key_stop) begin
                    len_we      = 1'b1;
                    len_wval    = {1'b0, wr_cnt};
                    rec_stop_nx = 1'b1;
                    state_nx    = IDLE;
                end else if (i_key_rec) begin
                    rec_start_nx = 1'b1;
                    state_nx     = RECD;
                end
            end
            PLAY: begin
                if (i_key_stop) begin
                    play_stop_nx = 1'b1;
                    state_nx     = IDLE;
                end else if (play_end) begin
`ifdef REC_PLAY_LOOP_EN
                    play_start_nx = 1'b1;
                    sec_clr       = 1'b1;
`else
                    play_stop_nx  = 1'b1;
                    state_nx      = IDLE;
`endif
                end else if (i_key_play) begin
                    play_pause_nx = 1'b1;
                    state_nx      = PLAY_PAUSE;
                end
            end
            PLAY_PAUSE: begin
                if (i_key_stop) begin
                    play_stop_nx = 1'b1;
                    state_nx     = IDLE;
                end else if (i_key_play) begin
                    play_start_nx = 1'b1;
                    state_nx      = PLAY;
                end
            end
            default: begin
                state_nx = INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= INIT;
            trk          <= '0;
            wr_cnt       <= '0;
            init_fired   <= 1'b0;
            o_init_start <= 1'b0;
            o_rec_start  <= 1'b0;
            o_rec_pause  <= 1'b0;
            o_rec_stop   <= 1'b0;
            o_play_start <= 1'b0;
            o_play_pause <= 1'b0;
            o_play_stop  <= 1'b0;
            for (int i = 0; i < NUM_TRACKS; i++) begin
                len_q[i] <= '0;
            end
        end else begin
            state        <= state_nx;
            trk          <= trk_nx;
            wr_cnt       <= wr_cnt_nx;
            init_fired   <= init_fired | init_start_nx;
            o_init_start <= init_start_nx;
            o_rec_start  <= rec_start_nx;
            o_rec_pause  <= rec_pause_nx;
            o_rec_stop   <= rec_stop_nx;
            o_play_start <= play_start_nx;
            o_play_pause <= play_pause_nx;
            o_play_stop  <= play_stop_nx;
            if (len_we) begin
                len_q[len_widx] <= len_wval;
            end
        end
    end

    assign o_sram_addr = {trk, (state == RECD) ? wr_cnt : i_play_off};
    assign o_sram_we_n = !((state == RECD) && i_rec_valid);
    assign o_play_en   = (state == PLAY);
    assign o_state     = state;

    sec_counter #(
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_sec_counter (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (sec_clr),
        .en    ((state == RECD) || (state == PLAY)),
        .tick  (i_sample_tick),
        .sec   (o_sec)
    );

endmodule

// File: tb/tb_rec_play_ctrl.sv
// tb_rec_play_ctrl: directed bench for rec_play_ctrl (ADDR_W=8, TRK_W=2,
// SAMPLE_RATE=4, so each partition holds 64 words).
module tb_rec_play_ctrl;
    import rec_play_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_rec, key_play, key_stop;
    logic [1:0] track;
    logic       init_done, rec_valid, sample_tick;
    logic [5:0] play_off;
    logic       init_start, rec_start, rec_pause, rec_stop;
    logic       play_start, play_pause, play_stop, play_en;
    logic [7:0] sram_addr;
    logic       sram_we_n;
    logic [2:0] state;
    logic [5:0] sec;

    int vectors     = 0;
    int miscompares = 0;
    int n_init      = 0;
    int n_rec_stop  = 0;
    int n_play_stop = 0;

    always #5 clk = ~clk;

    rec_play_ctrl #(
        .ADDR_W      (8),
        .TRK_W       (2),
        .SAMPLE_RATE (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_key_rec     (key_rec),
        .i_key_play    (key_play),
        .i_key_stop    (key_stop),
        .i_track       (track),
        .i_init_done   (init_done),
        .i_rec_valid   (rec_valid),
        .i_play_off    (play_off),
        .i_sample_tick (sample_tick),
        .o_init_start  (init_start),
        .o_rec_start   (rec_start),
        .o_rec_pause   (rec_pause),
        .o_rec_stop    (rec_stop),
        .o_play_start  (play_start),
        .o_play_pause  (play_pause),
        .o_play_stop   (play_stop),
        .o_play_en     (play_en),
        .o_sram_addr   (sram_addr),
        .o_sram_we_n   (sram_we_n),
        .o_state       (state),
        .o_sec         (sec)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (init_start) n_init++;
        if (rec_stop)   n_rec_stop++;
        if (play_stop)  n_play_stop++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
        track = 2'd0; init_done = 1'b0; rec_valid = 1'b0; sample_tick = 1'b0;
        play_off = 6'd0;

        // Reset state
        repeat (3) tick();
        chk("rst_state", 32'(state), 32'(INIT));
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_sec", 32'(sec), 32'd0);
        chk("rst_init_start", 32'(init_start), 32'd0);
        chk("rst_play_en", 32'(play_en), 32'd0);

        // INIT: start pulse in cycle 1, rec key ignored, IDLE at cycle 6
        rst_n = 1'b1;
        tick();
        chk("init_start_c1", 32'(init_start), 32'd1);
        chk("init_state_c1", 32'(state), 32'(INIT));
        key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        chk("init_start_c2", 32'(init_start), 32'd0);
        chk("init_rec_ignored", 32'(state), 32'(INIT));
        chk("init_no_rec_start", 32'(rec_start), 32'd0);
        repeat (3) tick();
        init_done = 1'b1;
        chk("init_state_c5", 32'(state), 32'(INIT));
        tick();
        chk("idle_c6", 32'(state), 32'(IDLE));
        chk("init_pulse_count", 32'(n_init), 32'd1);

        // Track 2: 10 words then stop
        track = 2'd2; key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        chk("t2_state_recd", 32'(state), 32'(RECD));
        chk("t2_rec_start", 32'(rec_start), 32'd1);
        chk("t2_addr0_idle", 32'(sram_addr), 32'd128);
        chk("t2_we_n_idle", 32'(sram_we_n), 32'd1);
        for (int i = 0; i < 10; i++) begin
            rec_valid = 1'b1;
            #1;
            chk("t2_wr_addr", 32'(sram_addr), 32'(128 + i));
            chk("t2_wr_we_n", 32'(sram_we_n), 32'd0);
            tick();
        end
        rec_valid = 1'b0;
        #1;
        chk("t2_addr_after", 32'(sram_addr), 32'd138);
        chk("t2_rec_start_once", 32'(rec_start), 32'd0);
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        chk("t2_stop_state", 32'(state), 32'(IDLE));
        chk("t2_rec_stop", 32'(rec_stop), 32'd1);
        tick();
        chk("t2_rec_stop_clear", 32'(rec_stop), 32'd0);
        chk("t2_rec_stop_count", 32'(n_rec_stop), 32'd1);

        // Track 1: fill all 64 words, auto-stop
        track = 2'd1; key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rec_valid = 1'b1;
            #1;
            if (i == 0)  chk("t1_first_addr", 32'(sram_addr), 32'd64);
            if (i == 63) begin
                chk("t1_last_addr", 32'(sram_addr), 32'd127);
                chk("t1_last_we_n", 32'(sram_we_n), 32'd0);
            end
            tick();
        end
        rec_valid = 1'b0;
        chk("t1_full_state", 32'(state), 32'(IDLE));
        chk("t1_full_rec_stop", 32'(rec_stop), 32'd1);
        tick();
        chk("t1_rec_stop_count", 32'(n_rec_stop), 32'd2);

        // Play on empty track 3 is ignored
        track = 2'd3; key_play = 1'b1;
        tick();
        key_play = 1'b0;
        chk("t3_empty_state", 32'(state), 32'(IDLE));
        chk("t3_empty_no_start", 32'(play_start), 32'd0);

        // rec+play+stop together in IDLE: stop wins, nothing happens
        track = 2'd2; key_rec = 1'b1; key_play = 1'b1; key_stop = 1'b1;
        tick();
        key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
        chk("all_keys_state", 32'(state), 32'(IDLE));
        chk("all_keys_rec_start", 32'(rec_start), 32'd0);
        chk("all_keys_play_start", 32'(play_start), 32'd0);

        // Play track 2 (len 10) with ramping offset, pause/resume at offset 5
        track = 2'd2; play_off = 6'd0; key_play = 1'b1;
        tick();
        key_play = 1'b0;
        chk("p2_state", 32'(state), 32'(PLAY));
        chk("p2_play_start", 32'(play_start), 32'd1);
        chk("p2_play_en", 32'(play_en), 32'd1);
        for (int off = 1; off <= 10; off++) begin
            play_off = 6'(off);
            #1;
            chk("p2_addr", 32'(sram_addr), 32'(128 + off));
            tick();
            if (off < 10) chk("p2_still_play", 32'(state), 32'(PLAY));
            if (off == 5) begin
                key_play = 1'b1;
                tick();
                key_play = 1'b0;
                chk("p2_pause_state", 32'(state), 32'(PLAY_PAUSE));
                chk("p2_pause_pulse", 32'(play_pause), 32'd1);
                chk("p2_pause_en", 32'(play_en), 32'd0);
                key_play = 1'b1;
                tick();
                key_play = 1'b0;
                chk("p2_resume_state", 32'(state), 32'(PLAY));
                chk("p2_resume_start", 32'(play_start), 32'd1);
            end
        end
`ifdef REC_PLAY_LOOP_EN
        chk("p2_loop_state", 32'(state), 32'(PLAY));
        chk("p2_loop_start", 32'(play_start), 32'd1);
        chk("p2_loop_no_stop", 32'(play_stop), 32'd0);
        play_off = 6'd0; key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        chk("p2_stop_state", 32'(state), 32'(IDLE));
        chk("p2_stop_pulse", 32'(play_stop), 32'd1);
`else
        chk("p2_end_state", 32'(state), 32'(IDLE));
        chk("p2_end_stop", 32'(play_stop), 32'd1);
        play_off = 6'd0;
`endif
        tick();
        chk("p2_stop_count", 32'(n_play_stop), 32'd1);

        // Seconds: record track 0, 20 ticks -> 5, pause 40 ticks, 280 more -> 63
        track = 2'd0; key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        chk("s_start_sec", 32'(sec), 32'd0);
        sample_tick = 1'b1;
        repeat (20) tick();
        sample_tick = 1'b0;
        chk("s_sec_5", 32'(sec), 32'd5);
        key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        chk("s_pause_state", 32'(state), 32'(RECD_PAUSE));
        chk("s_pause_pulse", 32'(rec_pause), 32'd1);
        sample_tick = 1'b1;
        repeat (40) tick();
        sample_tick = 1'b0;
        chk("s_pause_hold", 32'(sec), 32'd5);
        key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        chk("s_resume_state", 32'(state), 32'(RECD));
        chk("s_resume_start", 32'(rec_start), 32'd1);
        sample_tick = 1'b1;
        repeat (280) tick();
        sample_tick = 1'b0;
        chk("s_sec_sat", 32'(sec), 32'd63);
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        chk("s_stop_state", 32'(state), 32'(IDLE));
        chk("s_rec_stop_count", 32'(n_rec_stop), 32'd2);
        tick();
        chk("s_rec_stop_count2", 32'(n_rec_stop), 32'd3);
        // Track 0 has zero length now
        key_play = 1'b1;
        tick();
        key_play = 1'b0;
        chk("s_t0_empty", 32'(state), 32'(IDLE));
        // Starting playback clears the seconds
        track = 2'd2; key_play = 1'b1;
        tick();
        key_play = 1'b0;
        chk("s_play_state", 32'(state), 32'(PLAY));
        chk("s_play_sec_clr", 32'(sec), 32'd0);
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
        chk("s_play_stop", 32'(play_stop), 32'd1);
        tick();
        chk("s_play_stop_count", 32'(n_play_stop), 32'd2);

        // Reset mid-record: no stop pulse, lengths lost
        track = 2'd2; key_rec = 1'b1;
        tick();
        key_rec = 1'b0;
        rec_valid = 1'b1;
        repeat (3) tick();
        rec_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mr_state", 32'(state), 32'(INIT));
        chk("mr_no_rec_stop", 32'(rec_stop), 32'd0);
        chk("mr_we_n", 32'(sram_we_n), 32'd1);
        rst_n = 1'b1;
        tick();
        chk("mr_init_start", 32'(init_start), 32'd1);
        chk("mr_idle", 32'(state), 32'(IDLE));
        track = 2'd1; key_play = 1'b1;
        tick();
        key_play = 1'b0;
        chk("mr_len_lost", 32'(state), 32'(IDLE));
        tick();
        chk("mr_rec_stop_count", 32'(n_rec_stop), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
